// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - funct3 width codes (LSU_B/H/W/BU/HU)
//   - FSM state type lsu_state_t
//   - helpers for legality, byte-enable pattern and misalignment detection
package lsu_pkg;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

  // Stores only have signed-style codes; loads add the unsigned variants.
  function automatic logic lsu_legal(input logic we, input logic [2:0] f3);
    if (we)
      return (f3 == LSU_B) || (f3 == LSU_H) || (f3 == LSU_W);
    return (f3 == LSU_B) || (f3 == LSU_H) || (f3 == LSU_W) ||
           (f3 == LSU_BU) || (f3 == LSU_HU);
  endfunction

  // sz is funct3[1:0]: 00 byte, 01 half, 10 word.
  function automatic logic [3:0] lsu_be(input logic [1:0] sz, input logic [1:0] lo);
    case (sz)
      2'b00:   return 4'b0001 << lo;
      2'b01:   return lo[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic lsu_misaligned(input logic [1:0] sz, input logic [1:0] lo);
    return ((sz == 2'b01) && lo[0]) || ((sz == 2'b10) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_ld_align.sv
// lsu_ld_align: combinational load lane select and sign/zero extension.
//   i_rdata   : raw 32-bit word from memory
//   i_addr_lo : byte offset within the word
//   i_funct3  : load width code
//   o_data    : extended load result (0 for non-load codes)
module lsu_ld_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_addr_lo)
      2'd0: w_byte = i_rdata[7:0];
      2'd1: w_byte = i_rdata[15:8];
      2'd2: w_byte = i_rdata[23:16];
      2'd3: w_byte = i_rdata[31:24];
      default: w_byte = i_rdata[7:0];
    endcase
  end

  assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    o_data = '0;
    case (i_funct3)
      LSU_B:   o_data = {{24{w_byte[7]}}, w_byte};
      LSU_H:   o_data = {{16{w_half[15]}}, w_half};
      LSU_W:   o_data = i_rdata;
      LSU_BU:  o_data = {24'h0, w_byte};
      LSU_HU:  o_data = {16'h0, w_half};
      default: o_data = '0;
    endcase
  end

endmodule

// File: rtl/lsu_unit.sv
// lsu_unit: load/store unit, one req/ack memory transaction per operation.
// Ports:
//   i_clk, i_rst (async, active-high)
//   i_valid/o_ready           : operation handshake (ready only when idle)
//   i_we, i_funct3, i_addr, i_wdata : operation fields
//   o_mem_req/we/addr/be/wdata : registered memory port, zero outside REQ
//   i_mem_ack, i_mem_rdata     : memory completion and read word
//   o_done, o_rdata, o_misalign : one-cycle completion result
// Build option: define LSU_MISALIGN_EN to fault misaligned half/word accesses;
// otherwise unused low address bits are ignored and o_misalign is always 0.
//
// state | meaning
// IDLE  | ready for a new operation
// REQ   | memory request outstanding, waiting for i_mem_ack
// DONE  | one-cycle result pulse (o_done)
module lsu_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_we,
  input  logic [2:0]        i_funct3,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [3:0]        o_mem_be,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic              i_mem_ack,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_done,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_misalign
);

  lsu_state_t r_state, w_state_nxt;

  logic              w_accept, w_legal, w_misalign, w_go_req, w_ack;
  logic [3:0]        w_be;
  logic [DATA_W-1:0] w_st_wdata, w_ld_ext;

  logic              r_mem_req, r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [3:0]        r_mem_be;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [2:0]        r_funct3;
  logic [1:0]        r_addr_lo;
  logic [DATA_W-1:0] r_rdata;
  logic              r_misalign;

  assign w_accept = i_valid & o_ready;
  assign w_legal  = lsu_legal(i_we, i_funct3);
`ifdef LSU_MISALIGN_EN
  assign w_misalign = w_legal & lsu_misaligned(i_funct3[1:0], i_addr[1:0]);
`else
  assign w_misalign = 1'b0;
`endif
  assign w_go_req = w_legal & ~w_misalign;
  assign w_ack    = (r_state == REQ) & i_mem_ack;
  assign w_be     = lsu_be(i_funct3[1:0], i_addr[1:0]);

  // Store data replicated into every lane the width could target; loads send 0.
  always_comb begin
    w_st_wdata = '0;
    if (i_we) begin
      case (i_funct3[1:0])
        2'b00:   w_st_wdata = {4{i_wdata[7:0]}};
        2'b01:   w_st_wdata = {2{i_wdata[15:0]}};
        default: w_st_wdata = i_wdata;
      endcase
    end
  end

  lsu_ld_align u_ld_align (
    .i_rdata   (i_mem_rdata),
    .i_addr_lo (r_addr_lo),
    .i_funct3  (r_funct3),
    .o_data    (w_ld_ext)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = w_go_req ? REQ : DONE;
      REQ:     if (i_mem_ack) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_ready = (r_state == IDLE);
    o_done  = (r_state == DONE);
  end

  // Result registers default to 0 so o_rdata/o_misalign are only non-zero in DONE.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_be    <= '0;
      r_mem_wdata <= '0;
      r_funct3    <= '0;
      r_addr_lo   <= '0;
      r_rdata     <= '0;
      r_misalign  <= 1'b0;
    end else begin
      r_rdata    <= '0;
      r_misalign <= 1'b0;
      if (w_accept) begin
        if (w_go_req) begin
          r_mem_req   <= 1'b1;
          r_mem_we    <= i_we;
          r_mem_addr  <= {i_addr[ADDR_W-1:2], 2'b00};
          r_mem_be    <= w_be;
          r_mem_wdata <= w_st_wdata;
          r_funct3    <= i_funct3;
          r_addr_lo   <= i_addr[1:0];
        end else begin
          r_misalign <= w_misalign;
        end
      end else if (w_ack) begin
        r_mem_req   <= 1'b0;
        r_mem_we    <= 1'b0;
        r_mem_addr  <= '0;
        r_mem_be    <= '0;
        r_mem_wdata <= '0;
        r_rdata     <= r_mem_we ? '0 : w_ld_ext;
      end
    end
  end

  assign o_mem_req   = r_mem_req;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_be    = r_mem_be;
  assign o_mem_wdata = r_mem_wdata;
  assign o_rdata     = r_rdata;
  assign o_misalign  = r_misalign;

endmodule

// File: tb/tb_lsu_unit.sv
// Testbench for lsu_unit: transaction-level reference model plus directed
// literal checks and a randomized phase.
module tb_lsu_unit;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_valid, i_we, i_mem_ack;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr, i_wdata, i_mem_rdata;
  logic        o_ready, o_mem_req, o_mem_we, o_done, o_misalign;
  logic [31:0] o_mem_addr, o_mem_wdata, o_rdata;
  logic [3:0]  o_mem_be;

  int n_vec = 0;
  int n_bad = 0;

  always #5 i_clk = ~i_clk;

  lsu_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_we        (i_we),
    .i_funct3    (i_funct3),
    .i_addr      (i_addr),
    .i_wdata     (i_wdata),
    .o_mem_req   (o_mem_req),
    .o_mem_we    (o_mem_we),
    .o_mem_addr  (o_mem_addr),
    .o_mem_be    (o_mem_be),
    .o_mem_wdata (o_mem_wdata),
    .i_mem_ack   (i_mem_ack),
    .i_mem_rdata (i_mem_rdata),
    .o_done      (o_done),
    .o_rdata     (o_rdata),
    .o_misalign  (o_misalign)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference rules ----------------
  function automatic logic m_legal(input logic we, input logic [2:0] f3);
    if (we) return f3 <= 3'd2;
    return (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
  endfunction

  function automatic logic m_misal(input logic [2:0] f3, input logic [1:0] lo);
`ifdef LSU_MISALIGN_EN
    if (f3[1:0] == 2'b01) return (lo % 2) != 0;
    if (f3[1:0] == 2'b10) return lo != 0;
`endif
    return 1'b0;
  endfunction

  function automatic logic [3:0] m_bemask(input logic [2:0] f3, input logic [1:0] lo);
    if (f3[1:0] == 2'b00) return 4'(1 << lo);
    if (f3[1:0] == 2'b01) return (lo >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wrep(input logic [2:0] f3, input logic [31:0] w);
    if (f3[1:0] == 2'b00) return (w & 32'hFF) * 32'h0101_0101;
    if (f3[1:0] == 2'b01) return (w & 32'hFFFF) * 32'h0001_0001;
    return w;
  endfunction

  function automatic logic [31:0] m_ext(input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * lo)) & 32'hFF;
    h = (w >> (16 * lo[1])) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'd128)   ? b - 32'd256   : b;
      3'd1:    return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'd2:    return w;
      3'd4:    return b;
      3'd5:    return h;
      default: return 32'h0;
    endcase
  endfunction

  // ---------------- transaction model ----------------
  logic        m_req = 0, m_done = 0, m_we = 0, m_mis = 0, m_acc = 0, m_rdy = 1;
  logic [31:0] m_addr = 0, m_wd = 0, m_rd = 0;
  logic [3:0]  m_be = 0;
  logic [2:0]  m_f3 = 0;
  logic [1:0]  m_lo = 0;

  initial forever begin
    @(posedge i_clk or posedge i_rst);
    if (i_rst) begin
      m_req = 0; m_done = 0; m_we = 0; m_mis = 0; m_acc = 0;
      m_addr = 0; m_wd = 0; m_rd = 0; m_be = 0; m_f3 = 0; m_lo = 0;
    end else begin
      m_rdy  = !m_req && !m_done;
      m_done = 0;
      m_acc  = 0;
      m_mis  = 0;
      m_rd   = 0;
      if (m_req && i_mem_ack) begin
        m_req  = 0;
        m_done = 1;
        m_rd   = m_we ? 32'h0 : m_ext(m_f3, m_lo, i_mem_rdata);
      end
      if (m_rdy && i_valid) begin
        m_acc = 1;
        if (m_legal(i_we, i_funct3) && !m_misal(i_funct3, i_addr[1:0])) begin
          m_req  = 1;
          m_we   = i_we;
          m_addr = i_addr & 32'hFFFF_FFFC;
          m_be   = m_bemask(i_funct3, i_addr[1:0]);
          m_wd   = m_wrep(i_funct3, i_wdata);
          m_f3   = i_funct3;
          m_lo   = i_addr[1:0];
        end else begin
          m_done = 1;
          m_mis  = m_legal(i_we, i_funct3) && m_misal(i_funct3, i_addr[1:0]);
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge i_clk);
    chk("ready", 32'(o_ready), 32'(!m_req && !m_done));
    chk("mem_req", 32'(o_mem_req), 32'(m_req));
    if (m_req) begin
      chk("mem_addr", o_mem_addr, m_addr);
      chk("mem_be", 32'(o_mem_be), 32'(m_be));
      chk("mem_we", 32'(o_mem_we), 32'(m_we));
      if (m_we) chk("mem_wdata", o_mem_wdata, m_wd);
    end else begin
      chk("mem_idle_fields", {o_mem_addr ^ o_mem_wdata, 32'(o_mem_be), 32'(o_mem_we)} == '0 ? 32'h0 : 32'h1, 32'h0);
    end
    chk("done", 32'(o_done), 32'(m_done));
    if (m_done) begin
      chk("rdata", o_rdata, m_rd);
      chk("misalign", 32'(o_misalign), 32'(m_mis));
    end
`ifndef LSU_MISALIGN_EN
    chk("misalign_tied", 32'(o_misalign), 32'h0);
`endif
  end

  // ---------------- directed operation driver ----------------
  logic [31:0] g_rd, g_addr, g_wd;
  logic [3:0]  g_be;
  logic        g_we, g_mis, g_req;
  int          g_lat;

  // Entered and left at posedge+1. Acks after 'waits' request cycles.
  task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rd, input int waits);
    int  n;
    bit  done;
    g_rd = 0; g_addr = 0; g_wd = 0; g_be = 0; g_we = 0; g_mis = 0; g_req = 0; g_lat = 0;
    n = 0;
    while (!o_ready && n < 20) begin
      @(posedge i_clk); #1;
      n++;
    end
    chk("op_ready", 32'(o_ready), 32'h1);
    i_valid = 1; i_we = we; i_funct3 = f3; i_addr = addr; i_wdata = wd;
    i_mem_ack = 0; i_mem_rdata = rd;
    @(posedge i_clk); #1;
    i_valid = 0;
    done = 0;
    for (int c = 1; c <= waits + 20 && !done; c++) begin
      if (o_mem_req) begin
        g_req = 1; g_addr = o_mem_addr; g_be = o_mem_be; g_wd = o_mem_wdata; g_we = o_mem_we;
      end
      if (o_done) begin
        done = 1; g_lat = c; g_rd = o_rdata; g_mis = o_misalign;
      end else begin
        i_mem_ack = o_mem_req && (c > waits);
        @(posedge i_clk); #1;
        i_mem_ack = 0;
      end
    end
  endtask

  initial begin
    i_valid = 0; i_we = 0; i_funct3 = 0; i_addr = 0; i_wdata = 0;
    i_mem_ack = 0; i_mem_rdata = 0;
    repeat (3) @(posedge i_clk);
    #1;
    chk("reset_ready", 32'(o_ready), 32'h1);
    chk("reset_done", 32'(o_done), 32'h0);
    i_rst = 0;
    @(posedge i_clk); #1;

    // LB sign-extended
    run_op(0, 3'b000, 32'h1003, 32'h0, 32'h80FF_1234, 0);
    chk("lb_addr", g_addr, 32'h1000);
    chk("lb_be", 32'(g_be), 32'h8);
    chk("lb_rdata", g_rd, 32'hFFFF_FF80);
    chk("lb_lat", 32'(g_lat), 32'd2);

    // LHU with 3 wait cycles
    run_op(0, 3'b101, 32'h2002, 32'h0, 32'hBEEF_0001, 3);
    chk("lhu_rdata", g_rd, 32'h0000_BEEF);
    chk("lhu_lat", 32'(g_lat), 32'd5);

    // SB
    run_op(1, 3'b000, 32'h11, 32'h1234_56A5, 32'hDEAD_BEEF, 1);
    chk("sb_be", 32'(g_be), 32'h2);
    chk("sb_wdata", g_wd, 32'hA5A5_A5A5);
    chk("sb_we", 32'(g_we), 32'h1);
    chk("sb_rdata", g_rd, 32'h0);

    // SH upper half
    run_op(1, 3'b001, 32'h22, 32'h0000_BEEF, 32'h0, 0);
    chk("sh_be", 32'(g_be), 32'hC);
    chk("sh_wdata", g_wd, 32'hBEEF_BEEF);

    // LH sign-extended, low half
    run_op(0, 3'b001, 32'h100, 32'h0, 32'h7777_8001, 0);
    chk("lh_rdata", g_rd, 32'hFFFF_8001);

    // Misaligned word
    run_op(0, 3'b010, 32'h6, 32'h0, 32'hCAFE_F00D, 0);
`ifdef LSU_MISALIGN_EN
    chk("mis_noreq", 32'(g_req), 32'h0);
    chk("mis_lat", 32'(g_lat), 32'd1);
    chk("mis_flag", 32'(g_mis), 32'h1);
    chk("mis_rdata", g_rd, 32'h0);
`else
    chk("mis_addr", g_addr, 32'h4);
    chk("mis_be", 32'(g_be), 32'hF);
    chk("mis_rdata", g_rd, 32'hCAFE_F00D);
    chk("mis_flag", 32'(g_mis), 32'h0);
`endif

    // Illegal load funct3
    run_op(0, 3'b011, 32'h40, 32'h0, 32'h1234_5678, 0);
    chk("ill_ld_noreq", 32'(g_req), 32'h0);
    chk("ill_ld_lat", 32'(g_lat), 32'd1);
    chk("ill_ld_rdata", g_rd, 32'h0);
    chk("ill_ld_mis", 32'(g_mis), 32'h0);

    // Illegal store funct3
    run_op(1, 3'b100, 32'h40, 32'hFFFF_FFFF, 32'h0, 0);
    chk("ill_st_noreq", 32'(g_req), 32'h0);
    chk("ill_st_lat", 32'(g_lat), 32'd1);

    // Reset in the middle of a request
    @(posedge i_clk); #1;
    i_valid = 1; i_we = 0; i_funct3 = 3'b010; i_addr = 32'h3000;
    @(posedge i_clk); #1;
    i_valid = 0;
    chk("rst_pre_req", 32'(o_mem_req), 32'h1);
    #2 i_rst = 1;
    #1;
    chk("rst_req_drop", 32'(o_mem_req), 32'h0);
    chk("rst_ready", 32'(o_ready), 32'h1);
    @(posedge i_clk); #1;
    i_rst = 0;
    for (int c = 0; c < 3; c++) begin
      chk("rst_no_done", 32'(o_done), 32'h0);
      @(posedge i_clk); #1;
    end
    run_op(0, 3'b010, 32'h40, 32'h0, 32'h1122_3344, 0);
    chk("b2b1_rdata", g_rd, 32'h1122_3344);
    chk("b2b1_lat", 32'(g_lat), 32'd2);
    run_op(0, 3'b010, 32'h44, 32'h0, 32'h5566_7788, 0);
    chk("b2b2_rdata", g_rd, 32'h5566_7788);
    chk("b2b2_addr", g_addr, 32'h44);

    // Randomized phase; the upstream holds a request until it is accepted.
    @(posedge i_clk); #1;
    i_valid = 0;
    for (int c = 0; c < 4000; c++) begin
      if (!i_valid || m_acc) begin
        if ($urandom_range(0, 2) != 0) begin
          i_valid  = 1;
          i_we     = 1'($urandom_range(0, 1));
          i_funct3 = 3'($urandom_range(0, 7));
          i_addr   = $urandom;
          i_wdata  = $urandom;
        end else begin
          i_valid = 0;
        end
      end
      i_mem_ack   = ($urandom_range(0, 3) == 0);
      i_mem_rdata = $urandom;
      @(posedge i_clk); #1;
    end
    i_valid = 0;
    i_mem_ack = 1;
    repeat (6) @(posedge i_clk);
    #1;
    i_mem_ack = 0;
    chk("drain_ready", 32'(o_ready), 32'h1);
    @(negedge i_clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/lsu_unit.md
# lsu_unit

Load/store unit directly downstream of the ALU in the execute path of the single-issue RV32I core. It takes the effective address computed by the ALU's `ALU_ADD` operation, together with the `funct3` width code and the store data. It runs one req/ack transaction on the data-memory port, producing byte enables and lane-replicated store data. Load results are sign- or zero-extended and returned to writeback with a one-cycle done pulse.

## Interface
- `ADDR_W`, 32, address width (full width passed on the memory port)
- `DATA_W`, 32, data width; only 32 is supported
- `i_clk`  in  1  clock, rising edge
- `i_rst`  in  1  reset, asynchronous, active-high
- `i_valid`  in  1  execute stage presents a memory operation
- `o_ready`  out  1  high only in IDLE; the operation is accepted when `i_valid & o_ready`
- `i_we`  in  1  1 = store, 0 = load
- `i_funct3`  in  3  RV32I width code (LB/LH/LW/LBU/LHU, SB/SH/SW)
- `i_addr`  in  ADDR_W  effective address from the ALU
- `i_wdata`  in  DATA_W  store data (rs2)
- `o_mem_req`  out  1  memory request
- `o_mem_we`  out  1  memory write
- `o_mem_addr`  out  ADDR_W  word-aligned address (`[1:0]` = 0)
- `o_mem_be`  out  4  byte enables
- `o_mem_wdata`  out  DATA_W  lane-replicated store data
- `i_mem_ack`  in  1  memory completion; sampled only in REQ
- `i_mem_rdata`  in  DATA_W  read word; valid when `i_mem_ack` is high
- `o_done`  out  1  one-cycle completion pulse
- `o_rdata`  out  DATA_W  extended load result; 0 for stores and faults
- `o_misalign`  out  1  misaligned-access fault, qualified by `o_done`

## Operation
**States**
- **IDLE → REQ:** on accept of a legal, aligned operation. All request fields are registered at this edge.
- **IDLE → DONE:** on accept of an illegal `funct3` or a faulting address. No memory access is made.
- **REQ → DONE:** on `i_mem_ack`. The extended read data is captured at this edge.
- **DONE → IDLE:** unconditionally after one cycle.

**Illegal `funct3`**
- Loads: 011, 110, 111. Stores: any value above 010.
- Result: `o_rdata` = 0, `o_misalign` = 0.

**Stores**
- SB: `be` = 1 << `addr[1:0]`; `wdata` = `{4{i_wdata[7:0]}}`.
- SH: `be` = `addr[1]` ? 1100 : 0011; `wdata` = `{2{i_wdata[15:0]}}`.
- SW: `be` = 1111; `wdata` = `i_wdata`.

**Loads**
- `o_mem_be` follows the same pattern as the corresponding store.
- The lane is selected by `addr[1:0]` (byte) or `addr[1]` (half).
- LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes the word through.

**Memory port**
- `o_mem_*` are driven from registers. They are 0 in all states except REQ.

## Timing
- **Reset values:** `o_ready` = 1; all other outputs 0; state = IDLE.
- **Accept (cycle 0):** `o_mem_req` rises at cycle 1 and stays high, with stable fields, until the cycle in which `i_mem_ack` is sampled high (cycle k ≥ 1).
- **Completion:** state is DONE at cycle k+1, with `o_done` = 1 and `o_rdata` valid for that cycle only.
- **Minimum latency:** accept to `o_done` is 2 cycles. The next accept is possible at k+2.
- **Fault / illegal `funct3`:** `o_done` at cycle 1.
- `i_mem_ack` outside REQ is ignored.
- `i_valid` while `o_ready` = 0 is not accepted. The upstream stage must hold the request.
- **Reset mid-transaction:** asynchronous return to IDLE. `o_mem_req` drops immediately, and the pending `o_done` is lost.

## Configuration
- **`LSU_MISALIGN_EN` defined:**
  - Misaligned means half with `addr[0]` = 1, or word with `addr[1:0]` ≠ 0.
  - A misaligned access goes to DONE without a memory access.
  - `o_done` = 1, `o_misalign` = 1, `o_rdata` = 0.
- **`LSU_MISALIGN_EN` undefined:**
  - Unused low address bits are ignored: half uses `addr[1]` only; word ignores `addr[1:0]`.
  - No fault is raised, and `o_misalign` is tied to 0.

## Structure
- **Package `lsu_pkg`:**
  - `funct3` constants `LSU_B` = 3'b000, `LSU_H` = 3'b001, `LSU_W` = 3'b010, `LSU_BU` = 3'b100, `LSU_HU` = 3'b101.
  - State enum `lsu_state_t` {IDLE, REQ, DONE}.
- **Sub-module `lsu_ld_align`:** combinational lane select and extension, taking (`rdata`, `addr[1:0]`, `funct3`) and producing the extended result.
- **Top level:** FSM and the store-side byte-enable/replication logic.

## Test plan
- **LB, sign-extended:** `addr` = 0x1003, memory returns 0x80FF_1234 → `o_mem_addr` = 0x1000, `be` = 1000, `o_rdata` = 0xFFFF_FF80.
- **LHU:** `addr` = 0x2002, `rdata` = 0xBEEF_0001, ack after 3 wait cycles → `o_rdata` = 0x0000_BEEF. `o_done` arrives exactly one cycle after the ack.
- **SB:** `addr` = 0x11, `wdata` = 0x1234_56A5 → `be` = 0010, `o_mem_wdata` = 0xA5A5_A5A5, `o_mem_we` = 1, `o_rdata` = 0.
- **Misaligned word, `addr` = 0x6:**
  - With `LSU_MISALIGN_EN`: no `o_mem_req`; `o_done` and `o_misalign` at cycle 1.
  - Without: access to 0x4, `be` = 1111.
- **Illegal `funct3` = 3'b011 load:** no `o_mem_req`; `o_done` = 1 at cycle 1, `o_rdata` = 0.
- **Reset mid-transaction:** `i_rst` pulsed while in REQ → `o_mem_req` drops within the cycle. Then a back-to-back LW completes with `o_ready` = 1 restored and no spurious `o_done`.
